// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared data memory sizes and sweep FSM encoding
package dmem_pkg;

  localparam int WORD_SIZE          = 10;
  localparam int DATA_MEM_SIZE      = 32;
  localparam int DATA_MEM_ADDR_SIZE = $clog2(DATA_MEM_SIZE);
  localparam int STARVE_CNT_W       = 4;

  // Word count widened by one bit so the range check is never a constant compare
  localparam logic [DATA_MEM_ADDR_SIZE:0] MEM_SIZE_EXT = DATA_MEM_SIZE[DATA_MEM_ADDR_SIZE:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_e;

  // True when the address maps onto a real word of the array
  function automatic logic addr_in_range(input logic [DATA_MEM_ADDR_SIZE-1:0] addr);
    return {1'b0, addr} < MEM_SIZE_EXT;
  endfunction

endpackage

// File: rtl/dmem_rr_guard.sv
// rtl/dmem_rr_guard.sv - fixed-priority grant with starvation guard for port 1
module dmem_rr_guard
  import dmem_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    p0_valid,
  input  logic                    p1_valid,
  output logic                    p0_ready,
  output logic                    p1_ready,
  output logic [STARVE_CNT_W-1:0] starve_cnt
);

  localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(STARVE_LIM);

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    force1;

  // Grant decision and next starvation count; count is frozen while not enabled
  always_comb begin
    force1       = p1_valid && (starve_cnt_q == LIM);
    p0_ready     = enable && p0_valid && !force1;
    p1_ready     = enable && p1_valid && (!p0_valid || force1);
    starve_cnt_d = starve_cnt_q;
    if (enable) begin
      if (p1_valid && !p1_ready) begin
        starve_cnt_d = (starve_cnt_q == LIM) ? LIM : starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_cnt = starve_cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter over single-port data memory with zero sweep
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          p0_valid,
  input  logic                          p0_we,
  input  logic [DATA_MEM_ADDR_SIZE-1:0] p0_addr,
  input  logic signed [WORD_SIZE-1:0]   p0_wdata,
  output logic                          p0_ready,
  output logic                          p0_rvalid,
  output logic signed [WORD_SIZE-1:0]   p0_rdata,
  input  logic                          p1_valid,
  input  logic                          p1_we,
  input  logic [DATA_MEM_ADDR_SIZE-1:0] p1_addr,
  input  logic signed [WORD_SIZE-1:0]   p1_wdata,
  output logic                          p1_ready,
  output logic                          p1_rvalid,
  output logic signed [WORD_SIZE-1:0]   p1_rdata,
  input  logic                          clear_start,
  output logic                          clear_busy,
  output logic                          clear_done
);

  localparam logic [DATA_MEM_ADDR_SIZE-1:0] LAST_ADDR = DATA_MEM_ADDR_SIZE'(DATA_MEM_SIZE - 1);

  logic signed [WORD_SIZE-1:0] mem [DATA_MEM_SIZE];

  sweep_state_e                  state_q, state_d;
  logic [DATA_MEM_ADDR_SIZE-1:0] sweep_addr_q, sweep_addr_d;
  logic                          p0_rvalid_q, p0_rvalid_d;
  logic                          p1_rvalid_q, p1_rvalid_d;
  logic signed [WORD_SIZE-1:0]   p0_rdata_q, p0_rdata_d;
  logic signed [WORD_SIZE-1:0]   p1_rdata_q, p1_rdata_d;

  logic                          mem_we;
  logic [DATA_MEM_ADDR_SIZE-1:0] mem_waddr;
  logic signed [WORD_SIZE-1:0]   mem_wdata;
  logic                          p0_xfer, p1_xfer;
  logic [STARVE_CNT_W-1:0]       starve_cnt;

  dmem_rr_guard #(
    .STARVE_LIM (STARVE_LIM)
  ) u_guard (
    .clk        (clk),
    .reset      (reset),
    .enable     (state_q == ST_IDLE),
    .p0_valid   (p0_valid),
    .p1_valid   (p1_valid),
    .p0_ready   (p0_ready),
    .p1_ready   (p1_ready),
    .starve_cnt (starve_cnt)
  );

  // Sweep FSM, the single memory write port and the registered read paths
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    mem_we       = 1'b0;
    mem_waddr    = p0_addr;
    mem_wdata    = p0_wdata;
    p0_xfer      = p0_valid && p0_ready;
    p1_xfer      = p1_valid && p1_ready;

    p0_rvalid_d  = p0_xfer && !p0_we;
    p1_rvalid_d  = p1_xfer && !p1_we;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    if (p0_rvalid_d) begin
      p0_rdata_d = addr_in_range(p0_addr) ? mem[p0_addr] : '0;
    end
    if (p1_rvalid_d) begin
      p1_rdata_d = addr_in_range(p1_addr) ? mem[p1_addr] : '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (p0_xfer && p0_we && addr_in_range(p0_addr)) begin
          mem_we    = 1'b1;
          mem_waddr = p0_addr;
          mem_wdata = p0_wdata;
        end else if (p1_xfer && p1_we && addr_in_range(p1_addr)) begin
          mem_we    = 1'b1;
          mem_waddr = p1_addr;
          mem_wdata = p1_wdata;
        end
        if (clear_start) begin
          state_d      = ST_CLEAR;
          sweep_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_addr_q;
        mem_wdata = '0;
        if (sweep_addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          sweep_addr_d = sweep_addr_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A reset edge must not disturb the array, even mid-sweep
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  // Control and read-data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sweep_addr_q <= '0;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      p0_rvalid_q  <= p0_rvalid_d;
      p1_rvalid_q  <= p1_rvalid_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign p0_rvalid  = p0_rvalid_q;
  assign p1_rvalid  = p1_rvalid_q;
  assign p0_rdata   = p0_rdata_q;
  assign p1_rdata   = p1_rdata_q;
  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic              clk;
  logic              reset;
  logic              p0_valid, p0_we, p0_ready, p0_rvalid;
  logic [4:0]        p0_addr;
  logic signed [9:0] p0_wdata, p0_rdata;
  logic              p1_valid, p1_we, p1_ready, p1_rvalid;
  logic [4:0]        p1_addr;
  logic signed [9:0] p1_wdata, p1_rdata;
  logic              clear_start, clear_busy, clear_done;

  int vectors;
  int miscompares;
  int exp_mem [32];

  dmem_arbiter #(.STARVE_LIM(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .p0_valid    (p0_valid),
    .p0_we       (p0_we),
    .p0_addr     (p0_addr),
    .p0_wdata    (p0_wdata),
    .p0_ready    (p0_ready),
    .p0_rvalid   (p0_rvalid),
    .p0_rdata    (p0_rdata),
    .p1_valid    (p1_valid),
    .p1_we       (p1_we),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p1_ready    (p1_ready),
    .p1_rvalid   (p1_rvalid),
    .p1_rdata    (p1_rdata),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input integer got, input integer exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic p0_write(input int addr, input int data);
    p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 5'(addr); p0_wdata = 10'(data);
    #1;
    check("p0_wr_ready", p0_ready, 1);
    step();
    p0_valid = 1'b0; p0_we = 1'b0;
  endtask

  task automatic p0_read(input string tag, input int addr, input int exp);
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 5'(addr);
    #1;
    check({tag, "_ready"}, p0_ready, 1);
    step();
    p0_valid = 1'b0;
    check({tag, "_rvalid"}, p0_rvalid, 1);
    check({tag, "_rdata"}, $signed(p0_rdata), exp);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; clear_start = 1'b0;
    p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    repeat (2) step();
    reset = 1'b0;
    #1;
    check("rst_p0_rvalid", p0_rvalid, 0);
    check("rst_p1_rvalid", p1_rvalid, 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_starve", dut.u_guard.starve_cnt, 0);

    // p0 write addr 3 = -7, read back the next cycle
    p0_write(3, -7);
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 5'd3;
    #1;
    check("wr_rd_ready", p0_ready, 1);
    check("wr_no_rvalid", p0_rvalid, 0);
    step();
    p0_valid = 1'b0;
    check("wr_rd_rvalid", p0_rvalid, 1);
    check("wr_rd_rdata", $signed(p0_rdata), -7);
    step();
    check("rvalid_one_cycle", p0_rvalid, 0);
    check("rdata_hold", $signed(p0_rdata), -7);

    // Fill every word with nonzero data, then sweep
    for (int i = 0; i < 32; i++) p0_write(i, i * 7 - 100 + (i == 14 ? 1 : 0));
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    p0_valid = 1'b1; p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 5'd9; p1_wdata = 10'd55;
    for (int k = 0; k < 32; k++) begin
      clear_start = (k == 5);
      #1;
      check("sweep_busy", clear_busy, 1);
      check("sweep_done_low", clear_done, 0);
      check("sweep_p0_ready", p0_ready, 0);
      check("sweep_p1_ready", p1_ready, 0);
      step();
    end
    clear_start = 1'b0;
    p0_valid = 1'b0; p1_valid = 1'b0; p1_we = 1'b0;
    #1;
    check("done_pulse", clear_done, 1);
    check("done_busy_low", clear_busy, 0);
    check("starve_frozen", dut.u_guard.starve_cnt, 0);
    step();
    check("done_one_cycle", clear_done, 0);
    for (int i = 0; i < 32; i++) p0_read("swept", i, 0);

    // p1 alone reads addr 0
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 5'd0;
    #1;
    check("p1_solo_ready", p1_ready, 1);
    check("p1_solo_p0_ready", p0_ready, 0);
    step();
    p1_valid = 1'b0;
    check("p1_solo_rvalid", p1_rvalid, 1);
    check("p1_solo_rdata", p1_rdata, 0);
    check("p1_solo_starve", dut.u_guard.starve_cnt, 0);

    // Starvation guard: p0 busy every cycle, p1 write held
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 5'd0;
    p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 5'd5; p1_wdata = 10'd42;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("starve_p1_ready", p1_ready, (k == 5) ? 1 : 0);
      check("starve_p0_ready", p0_ready, (k == 5) ? 0 : 1);
      if (p1_ready) begin
        step();
        p1_valid = 1'b0; p1_we = 1'b0;
      end else begin
        step();
      end
    end
    p0_valid = 1'b0;
    #1;
    check("starve_cleared", dut.u_guard.starve_cnt, 0);
    p0_read("starve_rd5", 5, 42);

    // Same address: p0 write 100 wins, p1 read follows and sees it
    p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 5'd7; p0_wdata = 10'd100;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 5'd7;
    #1;
    check("same_p0_first", p0_ready, 1);
    check("same_p1_wait", p1_ready, 0);
    step();
    p0_valid = 1'b0; p0_we = 1'b0;
    #1;
    check("same_p1_next", p1_ready, 1);
    step();
    p1_valid = 1'b0;
    check("same_p1_rvalid", p1_rvalid, 1);
    check("same_p1_rdata", p1_rdata, 100);

    // Reset after 10 sweep cycles: words 0..9 zero, rest untouched
    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = 200 - i * 13;
      p0_write(i, exp_mem[i]);
    end
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("part_busy", clear_busy, 1);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("part_idle_busy", clear_busy, 0);
    check("part_no_done", clear_done, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("part_no_done_later", clear_done, 0);
    end
    for (int i = 0; i < 32; i++) p0_read("part_rd", i, (i < 10) ? 0 : exp_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
